// File: rtl/ret_stoch_bit_counter.sv
// Early-terminating stochastic-to-binary converter.
// Counts the 1s of a unipolar bitstream, snapshots the running count each
// time the observed cycle count reaches a power of two, and reports the
// latest snapshot rescaled to WIDTH bits once counting has terminated.
module ret_stoch_bit_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pz,
   input  logic             done,
   output logic [WIDTH-1:0] Bz,
   output logic             done_p2
);

   localparam int KW = $clog2(WIDTH + 1);

   logic [WIDTH:0]   ctr;
   logic [WIDTH:0]   ones;
   logic [WIDTH:0]   snap;
   logic [KW-1:0]    snap_k;
   logic             term;
   logic             term_d1;

   logic [WIDTH:0]   ctr_next;
   logic [WIDTH:0]   ones_next;
   logic             is_pow2;
   logic [KW-1:0]    k_next;
   logic [KW-1:0]    shamt;
   logic [2*WIDTH:0] scaled;
   logic [WIDTH-1:0] next_bz;

   // Next counter values and power-of-two detection on the incremented cycle count.
   always_comb begin
      ctr_next  = ctr + 1'b1;
      ones_next = ones + {{WIDTH{1'b0}}, pz};
      is_pow2   = 1'b0;
      k_next    = '0;
      for (int i = 0; i <= WIDTH; i++) begin
         if (ctr_next == ((WIDTH + 1)'(1) << i)) begin
            is_pow2 = 1'b1;
            k_next  = KW'(i);
         end
      end
   end

   // Rescale the snapshot to full precision; snap can equal 2^k, so saturate.
   always_comb begin
      shamt  = KW'(WIDTH) - snap_k;
      scaled = {{WIDTH{1'b0}}, snap} << shamt;
      if (ctr == '0) begin
         next_bz = '0;
      end else if (|scaled[2*WIDTH:WIDTH]) begin
         next_bz = '1;
      end else begin
         next_bz = scaled[WIDTH-1:0];
      end
   end

   // Counting, snapshot, sticky termination and the two-stage completion pipeline.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctr     <= '0;
         ones    <= '0;
         snap    <= '0;
         snap_k  <= '0;
         term    <= 1'b0;
         term_d1 <= 1'b0;
         done_p2 <= 1'b0;
         Bz      <= '0;
      end else begin
         if (!term) begin
            if (done) begin
               // Early stop: the pz sampled on this edge is deliberately dropped.
               term <= 1'b1;
            end else begin
               ctr  <= ctr_next;
               ones <= ones_next;
               if (is_pow2) begin
                  snap   <= ones_next;
                  snap_k <= k_next;
               end
               if (ctr_next[WIDTH]) begin
                  term <= 1'b1;
               end
            end
         end
         term_d1 <= term;
         done_p2 <= done_p2 | term_d1;
         // The edge after term sets loads the final estimate; later edges hold it.
         if (!term_d1) begin
            Bz <= next_bz;
         end
      end
   end

endmodule

// File: tb/tb_ret_stoch_bit_counter.sv
// Directed bench for ret_stoch_bit_counter with hand-computed expectations.
module tb_ret_stoch_bit_counter;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             pz;
   logic             done;
   logic [WIDTH-1:0] Bz;
   logic             done_p2;

   int n_checks = 0;
   int n_fail   = 0;

   ret_stoch_bit_counter #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .pz      (pz),
      .done    (done),
      .Bz      (Bz),
      .done_p2 (done_p2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // One clock edge with the given inputs; outputs are sampled 1ns later.
   task automatic step(input logic p, input logic d);
      pz   = p;
      done = d;
      @(posedge clk);
      #1;
   endtask

   // Two reset edges with pz and done both high; state must come up cleared.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      chk({tag, "_bz"}, int'(Bz), 0);
      chk({tag, "_dp2"}, int'(done_p2), 0);
      rst_n = 1'b1;
      pz    = 1'b0;
      done  = 1'b0;
   endtask

   // Assert done for one edge (E0) and check the two-edge done_p2 latency.
   task automatic finish_with_done(input string tag, input int exp_bz);
      step(1'b1, 1'b1);
      chk({tag, "_dp2_e0"}, int'(done_p2), 0);
      step(1'b0, 1'b1);
      chk({tag, "_bz_e1"}, int'(Bz), exp_bz);
      chk({tag, "_dp2_e1"}, int'(done_p2), 0);
      step(1'b1, 1'b0);
      chk({tag, "_dp2_e2"}, int'(done_p2), 1);
      chk({tag, "_bz_e2"}, int'(Bz), exp_bz);
   endtask

   initial begin
      rst_n = 1'b0;
      pz    = 1'b0;
      done  = 1'b0;
      #2;

      // Reset, then done on the very first cycle: nothing counted, Bz=0.
      do_reset("rst0");
      finish_with_done("first_done", 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      chk("first_done_hold_bz", int'(Bz), 0);
      chk("first_done_hold_dp2", int'(done_p2), 1);

      // Alternating 1,0 for 123 cycles: last snapshot at 64 cycles, 32 ones -> 128.
      do_reset("rst_alt");
      for (int i = 0; i < 123; i++) begin
         step(((i % 2) == 0), 1'b0);
         if (i == 1) chk("alt_running_k0", int'(Bz), 255);
         if (i == 2) chk("alt_running_k1", int'(Bz), 128);
      end
      finish_with_done("alt", 128);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      chk("alt_hold_bz", int'(Bz), 128);
      chk("alt_hold_dp2", int'(done_p2), 1);

      // All ones for 64 cycles: 64<<2 = 256 saturates to 255.
      do_reset("rst_sat");
      for (int i = 0; i < 64; i++) step(1'b1, 1'b0);
      finish_with_done("sat", 255);

      // Short stream 1,0,1,1,0: snapshot at 4 cycles is 3 -> 3<<6 = 192.
      do_reset("rst_short");
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      finish_with_done("short", 192);

      // Natural end: pz=1 every 4th cycle for 256 cycles -> 64 ones, k=8 -> 64.
      do_reset("rst_nat");
      for (int i = 0; i < 256; i++) step(((i % 4) == 0), 1'b0);
      chk("nat_dp2_e0", int'(done_p2), 0);
      step(1'b1, 1'b0);
      chk("nat_bz_e1", int'(Bz), 64);
      chk("nat_dp2_e1", int'(done_p2), 0);
      step(1'b1, 1'b0);
      chk("nat_dp2_e2", int'(done_p2), 1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      chk("nat_hold_bz", int'(Bz), 64);
      chk("nat_hold_dp2", int'(done_p2), 1);

      // Reset after completion, then mid-stream reset after 50 ones.
      do_reset("rst_after_done");
      for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
      rst_n = 1'b0;
      step(1'b1, 1'b0);
      chk("mid_rst_bz", int'(Bz), 0);
      chk("mid_rst_dp2", int'(done_p2), 0);
      rst_n = 1'b1;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      finish_with_done("mid", 255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
      $fatal(1, "timeout");
   end

endmodule
